// File: rtl/ising_pkg.sv
// Shared types and sizing helpers for the Ising run controller.
package ising_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } run_state_t;

    localparam logic [4:0] WEIGHT_INIT_DEF = 5'b00100;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int addr_width(input int p);
        return (p <= 1) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/weight_regfile.sv
// Coupling-weight registers: host write port, range check and
// flattened bus toward the core.
module weight_regfile
    import ising_pkg::*;
#(
    parameter int NUM_WEIGHTS = 5,
    parameter logic [NUM_WEIGHTS-1:0] WEIGHT_INIT = WEIGHT_INIT_DEF,
    parameter int P = 3,
    parameter int AW = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [NUM_WEIGHTS-1:0]   wr_data,
    output logic                     wr_err,
    output logic [NUM_WEIGHTS*P-1:0] weights
);

    localparam logic [AW:0] P_X = (AW + 1)'(P);

    logic in_range;

    assign in_range = {1'b0, wr_addr} < P_X;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weights <= {P{WEIGHT_INIT}};
            wr_err  <= 1'b0;
        end else begin
            wr_err <= wr_en && !in_range;
            for (int k = 0; k < P; k++) begin
                if (wr_en && ({1'b0, wr_addr} == (AW + 1)'(k)))
                    weights[k*NUM_WEIGHTS +: NUM_WEIGHTS] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/ising_run_ctrl.sv
// Anneal-run sequencer: weight storage, core reset hold, free run
// and result capture behind a valid/ready handshake.
module ising_run_ctrl
    import ising_pkg::*;
#(
    parameter int N = 3,
    parameter int NUM_WEIGHTS = 5,
    parameter logic [NUM_WEIGHTS-1:0] WEIGHT_INIT = WEIGHT_INIT_DEF,
    parameter int RST_CYCLES = 4,
    localparam int P = num_pairs(N),
    localparam int AW = addr_width(P)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [NUM_WEIGHTS-1:0]   wr_data,
    output logic                     wr_err,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              run_cycles,
    input  logic [31:0]              cfg_counter_max,
    input  logic [31:0]              cfg_counter_cutoff,
    output logic                     busy,
    output logic [NUM_WEIGHTS*P-1:0] weights,
    output logic                     core_rstn,
    output logic [31:0]              counter_max,
    output logic [31:0]              counter_cutoff,
    input  logic [N-1:0]             phase,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N-1:0]             result
);

    run_state_t  state;
    logic [31:0] cnt;
    logic [31:0] run_len;

    assign wr_ready = (state == IDLE);
    assign busy     = (state == SETTLE) || (state == RUN);

    weight_regfile #(
        .NUM_WEIGHTS (NUM_WEIGHTS),
        .WEIGHT_INIT (WEIGHT_INIT),
        .P           (P),
        .AW          (AW)
    ) u_regs (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_valid && wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .weights (weights)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            run_len        <= '0;
            core_rstn      <= 1'b0;
            res_valid      <= 1'b0;
            result         <= '0;
            counter_max    <= '0;
            counter_cutoff <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= SETTLE;
                        cnt            <= 32'(RST_CYCLES - 1);
                        run_len        <= (run_cycles == '0) ? 32'd1 : run_cycles;
                        counter_max    <= cfg_counter_max;
                        counter_cutoff <= cfg_counter_cutoff;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state     <= RUN;
                        core_rstn <= 1'b1;
                        cnt       <= run_len - 32'd1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                RUN: begin
                    // abort wins over a completion in the same cycle
                    if (abort) begin
                        state     <= IDLE;
                        core_rstn <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= DONE;
                        result    <= phase;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        core_rstn <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
